exu_wb_arb: RTL and testbench

//  Writeback arbiter directly downstream of the ALU. Merges the registered ALU writeback with results from a

---
 rtl/exu_wb_arb_if.sv | 38 +++
 rtl/exu_wb_arb.sv | 136 +++++++++++++
 tb/tb_exu_wb_arb.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/exu_wb_arb_if.sv
// Writeback bus between the ALU/MDU producers and the register-file write port.
// The arbiter sits on the slave side. The producers and the register file sit on the master side.
interface exu_wb_arb_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] alu_wb_data;
  logic [4:0]      alu_wb_rd_addr;
  logic            alu_wb_rd_wr_en;

  logic            mdu_wb_valid;
  logic            mdu_wb_ready;
  logic [XLEN-1:0] mdu_wb_data;
  logic [4:0]      mdu_wb_rd_addr;

  logic            rf_wr_en;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;

  logic            exu_stall_req;
  logic            wb_pending;
  logic [63:0]     wb_count;

  modport slave (
    input  alu_wb_data, alu_wb_rd_addr, alu_wb_rd_wr_en,
    input  mdu_wb_valid, mdu_wb_data, mdu_wb_rd_addr,
    output mdu_wb_ready,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    output exu_stall_req, wb_pending, wb_count
  );

  modport master (
    output alu_wb_data, alu_wb_rd_addr, alu_wb_rd_wr_en,
    output mdu_wb_valid, mdu_wb_data, mdu_wb_rd_addr,
    input  mdu_wb_ready,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    input  exu_stall_req, wb_pending, wb_count
  );
endinterface

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: the ALU always owns the register-file port. MDU results take idle slots,
// either by bypass or from a small in-order FIFO. A starving FIFO head raises a stall request.
module exu_wb_arb #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rstn,
  exu_wb_arb_if.slave  wb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  wb_entry_t       mem_q [DEPTH];
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d;

  logic [CW-1:0]   starve_q, starve_d;
  logic            stall_q, stall_d;

  logic            rf_en_q, rf_en_d;
  logic [4:0]      rf_addr_q, rf_addr_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic [63:0]     count_q, count_d;

  logic            alu_valid;
  logic            fifo_empty;
  logic            fifo_full;
  logic            mdu_accept;
  logic            mdu_live;
  logic            deq;
  logic            bypass;
  logic            enq;
  wb_entry_t       head;

  assign head = mem_q[rd_ptr_q[PW-1:0]];

  // Slot arbitration and FIFO control
  always_comb begin
    alu_valid  = wb.alu_wb_rd_wr_en && (wb.alu_wb_rd_addr != 5'd0);
    fifo_empty = (rd_ptr_q == wr_ptr_q);
    fifo_full  = (rd_ptr_q[PW] != wr_ptr_q[PW]) &&
                 (rd_ptr_q[PW-1:0] == wr_ptr_q[PW-1:0]);
    mdu_accept = wb.mdu_wb_valid && !fifo_full;
    // A result for x0 completes the handshake but is dropped here, so it never occupies the FIFO
    mdu_live   = mdu_accept && (wb.mdu_wb_rd_addr != 5'd0);
    deq        = !alu_valid && !fifo_empty;
    bypass     = !alu_valid && fifo_empty && mdu_live;
    enq        = mdu_live && !bypass;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    starve_d  = starve_q;
    stall_d   = stall_q;
    rf_en_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    count_d   = count_q + {63'd0, rf_en_q};

    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;

    if (alu_valid) begin
      rf_en_d   = 1'b1;
      rf_addr_d = wb.alu_wb_rd_addr;
      rf_data_d = wb.alu_wb_data;
    end else if (deq) begin
      rf_en_d   = 1'b1;
      rf_addr_d = head.rd;
      rf_data_d = head.data;
    end else if (bypass) begin
      rf_en_d   = 1'b1;
      rf_addr_d = wb.mdu_wb_rd_addr;
      rf_data_d = wb.mdu_wb_data;
    end

    // Starvation counter saturates. Once the stall request is raised, it holds until the head drains.
    if (deq || fifo_empty) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else begin
      if (starve_q != CW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
      if (starve_q == CW'(STARVE_MAX)) stall_d = 1'b1;
    end
  end

  // Control state: synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rstn) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      rf_en_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      count_q   <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      rf_en_q   <= rf_en_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      count_q   <= count_d;
    end
  end

  // NOTE: the FIFO storage has no reset. Resetting the pointers empties it, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q[PW-1:0]] <= '{rd: wb.mdu_wb_rd_addr, data: wb.mdu_wb_data};
  end

  assign wb.mdu_wb_ready  = !fifo_full;
  assign wb.rf_wr_en      = rf_en_q;
  assign wb.rf_wr_addr    = rf_addr_q;
  assign wb.rf_wr_data    = rf_data_q;
  assign wb.exu_stall_req = stall_q;
  assign wb.wb_pending    = !fifo_empty;
  assign wb.wb_count      = count_q;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Directed bench for exu_wb_arb. It drives the bus one cycle at a time and samples 1 ns after each rising edge.
module tb_exu_wb_arb;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  exu_wb_arb_if #(.XLEN(32)) bus ();

  exu_wb_arb #(.XLEN(32), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .wb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ae, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bus.alu_wb_rd_wr_en = ae;
    bus.alu_wb_rd_addr  = ar;
    bus.alu_wb_data     = ad;
    bus.mdu_wb_valid    = mv;
    bus.mdu_wb_rd_addr  = mr;
    bus.mdu_wb_data     = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".en"},   {63'd0, bus.rf_wr_en}, {63'd0, en});
    check({tag, ".addr"}, {59'd0, bus.rf_wr_addr}, {59'd0, a});
    check({tag, ".data"}, {32'd0, bus.rf_wr_data}, {32'd0, d});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    idle();
    tick();
    tick();

    // Reset values
    check_rf("rst", 1'b0, 5'd0, 32'd0);
    check("rst.stall",   {63'd0, bus.exu_stall_req}, 64'd0);
    check("rst.ready",   {63'd0, bus.mdu_wb_ready}, 64'd1);
    check("rst.pending", {63'd0, bus.wb_pending}, 64'd0);
    check("rst.count",   bus.wb_count, 64'd0);
    rstn = 1'b1;
    tick();

    // 1. ALU only
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    tick();
    check_rf("alu", 1'b1, 5'd5, 32'hDEADBEEF);
    check("alu.count0", bus.wb_count, 64'd0);
    idle();
    tick();
    check_rf("alu.hold", 1'b0, 5'd5, 32'hDEADBEEF);
    check("alu.count1", bus.wb_count, 64'd1);

    // 2. MDU bypass
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12);
    tick();
    check_rf("byp", 1'b1, 5'd7, 32'h12);
    check("byp.pending", {63'd0, bus.wb_pending}, 64'd0);
    idle();
    tick();
    check("byp.count", bus.wb_count, 64'd2);

    // 3. Conflict: the ALU wins, and the MDU result follows one cycle later
    drive(1'b1, 5'd1, 32'h111, 1'b1, 5'd2, 32'h222);
    tick();
    check_rf("cfl.alu", 1'b1, 5'd1, 32'h111);
    check("cfl.pending1", {63'd0, bus.wb_pending}, 64'd1);
    idle();
    tick();
    check_rf("cfl.mdu", 1'b1, 5'd2, 32'h222);
    check("cfl.pending0", {63'd0, bus.wb_pending}, 64'd0);
    tick();
    check("cfl.count", bus.wb_count, 64'd4);
    check("cfl.idle_en", {63'd0, bus.rf_wr_en}, 64'd0);

    // 4. Fill the FIFO under continuous ALU traffic, starve the head, then drain through one bubble
    for (int i = 0; i < 6; i++) begin
      logic [4:0] mrd;
      mrd = (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12;
      drive(1'b1, 5'd3, 32'(i), 1'b1, mrd, {24'd0, 3'd0, mrd} << 4);
      tick();
      check_rf($sformatf("full.alu%0d", i), 1'b1, 5'd3, 32'(i));
      check($sformatf("full.ready%0d", i), {63'd0, bus.mdu_wb_ready}, (i == 0) ? 64'd1 : 64'd0);
      check($sformatf("full.stall%0d", i), {63'd0, bus.exu_stall_req}, (i == 5) ? 64'd1 : 64'd0);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0);
    tick();
    check_rf("full.drain10", 1'b1, 5'd10, 32'hA0);
    check("full.ready_back", {63'd0, bus.mdu_wb_ready}, 64'd1);
    check("full.stall_clr", {63'd0, bus.exu_stall_req}, 64'd0);
    check("full.pending", {63'd0, bus.wb_pending}, 64'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0);
    tick();
    check_rf("full.drain11", 1'b1, 5'd11, 32'hB0);
    idle();
    tick();
    check_rf("full.drain12", 1'b1, 5'd12, 32'hC0);
    check("full.empty", {63'd0, bus.wb_pending}, 64'd0);
    check("full.count12", bus.wb_count, 64'd12);
    tick();
    check("full.count13", bus.wb_count, 64'd13);

    // 5. x0: a dropped ALU write frees the slot for the queued MDU entry
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99);
    tick();
    check_rf("x0.alu4", 1'b1, 5'd4, 32'h44);
    check("x0.pending", {63'd0, bus.wb_pending}, 64'd1);
    drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
    tick();
    check_rf("x0.deq", 1'b1, 5'd9, 32'h99);
    check("x0.pending0", {63'd0, bus.wb_pending}, 64'd0);
    drive(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'hBAD);
    tick();
    check("x0.count15", bus.wb_count, 64'd15);
    check_rf("x0.drop", 1'b0, 5'd9, 32'h99);
    check("x0.drop_pending", {63'd0, bus.wb_pending}, 64'd0);
    idle();
    tick();
    check("x0.count_same", bus.wb_count, 64'd15);

    // 6. Reset with two entries queued
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd20, 32'h20);
    tick();
    drive(1'b1, 5'd6, 32'h67, 1'b1, 5'd21, 32'h21);
    tick();
    check("rst2.full", {63'd0, bus.mdu_wb_ready}, 64'd0);
    idle();
    rstn = 1'b0;
    tick();
    check_rf("rst2", 1'b0, 5'd0, 32'd0);
    check("rst2.ready",   {63'd0, bus.mdu_wb_ready}, 64'd1);
    check("rst2.pending", {63'd0, bus.wb_pending}, 64'd0);
    check("rst2.stall",   {63'd0, bus.exu_stall_req}, 64'd0);
    check("rst2.count",   bus.wb_count, 64'd0);
    rstn = 1'b1;
    tick();
    check("rst2.no_stale1", {63'd0, bus.rf_wr_en}, 64'd0);
    tick();
    check("rst2.no_stale2", {63'd0, bus.rf_wr_en}, 64'd0);
    check("rst2.count_after", bus.wb_count, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
